// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage load/store responder for a 16-bit asynchronous SRAM.
// Each 32-bit access becomes two 16-bit phases (LOW, then HIGH), followed by
// a one-cycle DONE state in which ready rises so the pipeline can advance.
// The SRAM-side outputs are registered. They are loaded from the next-state
// decode, so address, data and strobe are stable for a whole phase and only
// change on the clock edge that enters or leaves it.
//
// Handshake: a request (Mem_W_EN | Mem_R_EN) is held by the frozen pipeline
// until ready=1. ready is combinational. It is 1 when nothing is requested or
// when the access completes this cycle (DONE). Transfer happens on the rising
// edge where both the request and ready are 1.
module sram_mem_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_W_EN,
  input  logic        Mem_R_EN,
  input  logic [31:0] ALU_res,
  input  logic [31:0] Val_Rm,
  output logic [31:0] Mem_Data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0]  LP_WAIT = 3'(WAIT_CYCLES);
  localparam logic [31:0] LP_BASE = 32'(BASE_ADDR);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic        r_is_wr;
  logic [31:0] r_mem_data;
  logic [17:0] r_sram_addr;
  logic [15:0] r_sram_dq;
  logic        r_sram_oe;
  logic        r_sram_we_n;

  logic [31:0] w_m;
  logic        w_req;
  logic        w_phase_end;
  logic        w_wr_nxt;
  logic [17:0] w_addr_nxt;
  logic [15:0] w_dq_nxt;
  logic        w_oe_nxt;
  logic        w_we_n_nxt;
  logic        w_unused_bits;

  // Halfword address from the byte offset into SRAM space; the byte lane bits
  // and bits beyond the 256K-halfword range are intentionally dropped.
  assign w_m           = ALU_res - LP_BASE;
  assign w_unused_bits = &{1'b0, w_m[31:19], w_m[1:0]};
  assign w_req         = Mem_W_EN | Mem_R_EN;
  assign w_phase_end   = (r_cnt == LP_WAIT);
  // Op type is sampled on acceptance in IDLE (write wins), then held.
  assign w_wr_nxt      = (r_state == S_IDLE) ? Mem_W_EN : r_is_wr;

  assign ready       = ~w_req | (r_state == S_DONE);
  assign Mem_Data    = r_mem_data;
  assign SRAM_ADDR   = r_sram_addr;
  assign SRAM_DQ_out = r_sram_dq;
  assign SRAM_DQ_oe  = r_sram_oe;
  assign SRAM_WE_N   = r_sram_we_n;
  assign o_state     = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; once started an access always runs to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_state_nxt = S_LOW;
      S_LOW:   if (w_phase_end) w_state_nxt = S_HIGH;
      S_HIGH:  if (w_phase_end) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // SRAM pin values for the state being entered; registered below.
  always_comb begin
    w_addr_nxt = '0;
    w_dq_nxt   = '0;
    w_oe_nxt   = 1'b0;
    w_we_n_nxt = 1'b1;
    case (w_state_nxt)
      S_LOW: begin
        w_addr_nxt = {w_m[18:2], 1'b0};
        if (w_wr_nxt) begin
          w_dq_nxt   = Val_Rm[15:0];
          w_oe_nxt   = 1'b1;
          w_we_n_nxt = 1'b0;
        end
      end
      S_HIGH: begin
        w_addr_nxt = {w_m[18:2], 1'b1};
        if (w_wr_nxt) begin
          w_dq_nxt   = Val_Rm[31:16];
          w_oe_nxt   = 1'b1;
          w_we_n_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Phase counter, latched op type and load-data capture at each phase end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_is_wr    <= 1'b0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_req) r_is_wr <= Mem_W_EN;
        end
        S_LOW: begin
          r_cnt <= w_phase_end ? 3'd0 : r_cnt + 3'd1;
          if (w_phase_end && !r_is_wr) r_mem_data[15:0] <= SRAM_DQ_in;
        end
        S_HIGH: begin
          r_cnt <= w_phase_end ? 3'd0 : r_cnt + 3'd1;
          if (w_phase_end && !r_is_wr) r_mem_data[31:16] <= SRAM_DQ_in;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Registered SRAM pins; reset forces the write strobe high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sram_addr <= '0;
      r_sram_dq   <= '0;
      r_sram_oe   <= 1'b0;
      r_sram_we_n <= 1'b1;
    end else begin
      r_sram_addr <= w_addr_nxt;
      r_sram_dq   <= w_dq_nxt;
      r_sram_oe   <= w_oe_nxt;
      r_sram_we_n <= w_we_n_nxt;
    end
  end

endmodule
